// File: rtl/pipe_hazard_responder.sv
// Consumer side of the hazard/stall handshake. It owns the PC, the fetch
// pipeline register, IF/ID and ID/EX. It applies hold and bubble requests
// and branch/jump/JR redirects, squashes wrong-path fetches for SHADOW edges
// after a redirect, and runs a consecutive-stall watchdog.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   PC_write_en                1 = PC advances, 0 = PC holds
//   IF_ID_write_en             1 = IF/ID loads, 0 = IF/ID holds
//   stall_flush                1 = inject a bubble into ID/EX
//   redirect_valid/_target     taken branch / jump / JR and its new PC
//   imem_instr                 instruction for the PC presented last cycle
//   id_ctrl                    decoded control of the IF/ID instruction
//   pc                         fetch address to imem
//   if_id_instr/_pc4/_valid    IF/ID register (instr 0 = NOP when squashed)
//   id_ex_ctrl/_valid          ID/EX register (ctrl 0 = bubble)
//   stall_timeout              sticky watchdog flag
//   bubble_count               bubble/squash counter
//
// Optional feature: define STALL_PERF_EN to build the bubble counter.
// When it is left undefined, bubble_count is tied to zero.
module pipe_hazard_responder #(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       INSTR_W     = 32,
  parameter int unsigned       CTRL_W      = 16,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int unsigned       SHADOW      = 1,
  parameter int unsigned       STALL_LIMIT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               PC_write_en,
  input  logic               IF_ID_write_en,
  input  logic               stall_flush,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic [CTRL_W-1:0]  id_ctrl,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc4,
  output logic               if_id_valid,
  output logic [CTRL_W-1:0]  id_ex_ctrl,
  output logic               id_ex_valid,
  output logic               stall_timeout,
  output logic [15:0]        bubble_count
);

  localparam int unsigned SW = $clog2(STALL_LIMIT + 1);

  logic [ADDR_W-1:0] fpc;          // PC whose instruction is on imem_instr
  logic              fetch_valid;  // fpc/imem_instr hold a real fetch
  logic [1:0]        shadow;       // remaining wrong-path squash edges
  logic [SW-1:0]     stall_cnt;

  logic pc_load_c;
  logic shadow_squash_c;
  logic stall_c;

  assign pc_load_c       = redirect_valid | PC_write_en;
  assign shadow_squash_c = (shadow != 2'd0) & IF_ID_write_en;
  assign stall_c         = ~PC_write_en & ~redirect_valid;

  // PC, fetch register, IF/ID, ID/EX and watchdog
  always_ff @(posedge clk) begin
    if (reset) begin
      pc            <= RESET_PC;
      fpc           <= RESET_PC;
      fetch_valid   <= 1'b0;
      if_id_instr   <= '0;
      if_id_pc4     <= '0;
      if_id_valid   <= 1'b0;
      shadow        <= 2'd0;
      id_ex_ctrl    <= '0;
      id_ex_valid   <= 1'b0;
      stall_cnt     <= '0;
      stall_timeout <= 1'b0;
    end else begin
      // A redirect outranks a stall, so PC_write_en is ignored under redirect
      if (redirect_valid)   pc <= redirect_target;
      else if (PC_write_en) pc <= pc + ADDR_W'(4);

      if (pc_load_c) begin
        fpc         <= pc;
        fetch_valid <= 1'b1;
      end

      // The first fetch after reset is not yet on imem_instr, so it loads as a NOP
      if (redirect_valid) begin
        if_id_instr <= '0;
        if_id_valid <= 1'b0;
        shadow      <= 2'(SHADOW);
      end else if (shadow_squash_c) begin
        if_id_instr <= '0;
        if_id_valid <= 1'b0;
        shadow      <= shadow - 2'd1;
      end else if (IF_ID_write_en) begin
        if_id_instr <= fetch_valid ? imem_instr : '0;
        if_id_pc4   <= fpc + ADDR_W'(4);
        if_id_valid <= fetch_valid;
      end

      if (stall_flush) begin
        id_ex_ctrl  <= '0;
        id_ex_valid <= 1'b0;
      end else begin
        id_ex_ctrl  <= if_id_valid ? id_ctrl : '0;
        id_ex_valid <= if_id_valid;
      end

      // The flag sets on the edge where the counter reaches the limit
      if (stall_c) begin
        if (stall_cnt != SW'(STALL_LIMIT)) stall_cnt <= stall_cnt + SW'(1);
        if (stall_cnt == SW'(STALL_LIMIT - 1)) stall_timeout <= 1'b1;
      end else begin
        stall_cnt <= '0;
      end
    end
  end

`ifdef STALL_PERF_EN
  logic squash_c;
  assign squash_c = redirect_valid | shadow_squash_c;

  // Flush and squash in the same cycle count once
  always_ff @(posedge clk) begin
    if (reset)                        bubble_count <= 16'h0;
    else if (stall_flush | squash_c)  bubble_count <= bubble_count + 16'd1;
  end
`else
  assign bubble_count = 16'h0;
`endif

endmodule
